// File: rtl/avmm_rd_mux_arbiter.sv
// Round-robin Avalon-MM burst-read arbiter: NUM_CH read slaves onto one read master, in-order beat steering.
// Optional per-channel performance counters are enabled with `define AVMM_RD_MUX_PERF_EN.
module avmm_rd_mux_arbiter #(
   parameter int NUM_CH    = 4,
   parameter int ADDR_W    = 64,
   parameter int DATA_W    = 512,
   parameter int BURST_W   = 5,
   parameter int TAG_DEPTH = 16,
   parameter int MAX_BEATS = 64
) (
   input  logic                      clk_clk,
   input  logic                      reset_reset,
   input  logic [NUM_CH-1:0]         s_read,
   input  logic [NUM_CH*ADDR_W-1:0]  s_address,
   input  logic [NUM_CH*BURST_W-1:0] s_burstcount,
   output logic [NUM_CH-1:0]         s_waitrequest,
   output logic [DATA_W-1:0]         s_readdata,
   output logic [NUM_CH-1:0]         s_readdatavalid,
   output logic                      m_read,
   output logic [ADDR_W-1:0]         m_address,
   output logic [BURST_W-1:0]        m_burstcount,
   input  logic                      m_waitrequest,
   input  logic [DATA_W-1:0]         m_readdata,
   input  logic                      m_readdatavalid,
   output logic                      err_unexpected
`ifdef AVMM_RD_MUX_PERF_EN
   ,
   output logic [NUM_CH*32-1:0]      perf_bursts,
   output logic [NUM_CH*32-1:0]      perf_stall
`endif
);

   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int PTR_W = $clog2(TAG_DEPTH);
   localparam int OUT_W = $clog2(MAX_BEATS + (1 << BURST_W)) + 1;

   logic [CH_W-1:0]    rr_ptr;
   logic [CH_W-1:0]    sel_ch;
   logic               sel_found;
   logic [BURST_W-1:0] sel_raw;
   logic [BURST_W-1:0] sel_burst;

   logic [CH_W-1:0]    tag_ch    [TAG_DEPTH];
   logic [BURST_W-1:0] tag_burst [TAG_DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [PTR_W:0]     tag_cnt;
   logic [BURST_W-1:0] beat_cnt;
   logic [OUT_W-1:0]   outstanding;

   logic accept, fifo_full, fifo_empty, credit_ok, grant_en, beat_ok, pop;
   logic [NUM_CH-1:0] grant;

   always_comb begin
      int idx;
      sel_found = 1'b0;
      sel_ch    = '0;
      idx       = 0;
      for (int k = 0; k < NUM_CH; k++) begin
         idx = (int'(rr_ptr) + k) % NUM_CH;
         if (!sel_found && s_read[idx]) begin
            sel_found = 1'b1;
            sel_ch    = CH_W'(idx);
         end
      end
   end

   // burstcount 0 is promoted to 1 so credit, tag and master request all agree
   assign sel_raw    = s_burstcount[sel_ch*BURST_W +: BURST_W];
   assign sel_burst  = (sel_raw == '0) ? BURST_W'(1) : sel_raw;

   assign accept     = ~m_read | ~m_waitrequest;
   assign fifo_full  = (tag_cnt == (PTR_W+1)'(TAG_DEPTH));
   assign fifo_empty = (tag_cnt == '0);
   assign credit_ok  = (outstanding + OUT_W'(sel_burst)) <= OUT_W'(MAX_BEATS);
   assign grant_en   = ~reset_reset & sel_found & accept & ~fifo_full & credit_ok;
   assign grant      = grant_en ? (NUM_CH'(1) << sel_ch) : '0;
   assign s_waitrequest = ~grant;

   assign beat_ok = m_readdatavalid & ~fifo_empty;
   assign pop     = beat_ok & (beat_cnt == tag_burst[rd_ptr] - BURST_W'(1));

   always_ff @(posedge clk_clk) begin
      if (grant_en) begin
         tag_ch[wr_ptr]    <= sel_ch;
         tag_burst[wr_ptr] <= sel_burst;
      end
   end

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         rr_ptr          <= '0;
         wr_ptr          <= '0;
         rd_ptr          <= '0;
         tag_cnt         <= '0;
         beat_cnt        <= '0;
         outstanding     <= '0;
         m_read          <= 1'b0;
         m_address       <= '0;
         m_burstcount    <= '0;
         s_readdata      <= '0;
         s_readdatavalid <= '0;
         err_unexpected  <= 1'b0;
      end else begin
         if (grant_en) begin
            rr_ptr       <= (sel_ch == CH_W'(NUM_CH-1)) ? '0 : sel_ch + CH_W'(1);
            wr_ptr       <= wr_ptr + PTR_W'(1);
            m_read       <= 1'b1;
            m_address    <= s_address[sel_ch*ADDR_W +: ADDR_W];
            m_burstcount <= sel_burst;
         end else if (accept) begin
            m_read <= 1'b0;
         end

         if (grant_en && !pop)
            tag_cnt <= tag_cnt + (PTR_W+1)'(1);
         else if (!grant_en && pop)
            tag_cnt <= tag_cnt - (PTR_W+1)'(1);

         outstanding <= outstanding + (grant_en ? OUT_W'(sel_burst) : '0)
                                    - (beat_ok ? OUT_W'(1) : '0);

         s_readdatavalid <= '0;
         if (beat_ok) begin
            s_readdata      <= m_readdata;
            s_readdatavalid <= NUM_CH'(1) << tag_ch[rd_ptr];
            if (pop) begin
               beat_cnt <= '0;
               rd_ptr   <= rd_ptr + PTR_W'(1);
            end else begin
               beat_cnt <= beat_cnt + BURST_W'(1);
            end
         end else if (m_readdatavalid) begin
            err_unexpected <= 1'b1;
         end
      end
   end

`ifdef AVMM_RD_MUX_PERF_EN
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         perf_bursts <= '0;
         perf_stall  <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (grant[i])
               perf_bursts[i*32 +: 32] <= perf_bursts[i*32 +: 32] + 32'd1;
            if (s_read[i] && s_waitrequest[i])
               perf_stall[i*32 +: 32] <= perf_stall[i*32 +: 32] + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_avmm_rd_mux_arbiter.sv
// Bench for avmm_rd_mux_arbiter: directed scenarios plus random traffic against a queue-based reference model.
module tb_avmm_rd_mux_arbiter;
   localparam int NC = 4;
   localparam int AW = 64;
   localparam int DW = 512;
   localparam int BW = 5;
   localparam int DEPTH = 16;
   localparam int MAXB = 64;

   logic              clk_clk = 1'b0;
   logic              reset_reset = 1'b1;
   logic [NC-1:0]     s_read = '0;
   logic [NC*AW-1:0]  s_address = '0;
   logic [NC*BW-1:0]  s_burstcount = '0;
   logic [NC-1:0]     s_waitrequest;
   logic [DW-1:0]     s_readdata;
   logic [NC-1:0]     s_readdatavalid;
   logic              m_read;
   logic [AW-1:0]     m_address;
   logic [BW-1:0]     m_burstcount;
   logic              m_waitrequest = 1'b0;
   logic [DW-1:0]     m_readdata = '0;
   logic              m_readdatavalid = 1'b0;
   logic              err_unexpected;

   avmm_rd_mux_arbiter #(.NUM_CH(NC), .ADDR_W(AW), .DATA_W(DW), .BURST_W(BW),
                         .TAG_DEPTH(DEPTH), .MAX_BEATS(MAXB)) dut (
      .clk_clk(clk_clk), .reset_reset(reset_reset),
      .s_read(s_read), .s_address(s_address), .s_burstcount(s_burstcount),
      .s_waitrequest(s_waitrequest), .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
      .m_read(m_read), .m_address(m_address), .m_burstcount(m_burstcount),
      .m_waitrequest(m_waitrequest), .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
      .err_unexpected(err_unexpected));

   always #5 clk_clk = ~clk_clk;

   int n_chk = 0;
   int n_fail = 0;

   // reference model: pending bursts as (channel, beats remaining) queues
   logic [AW-1:0] addr_in [NC];
   int            rr;
   int            outst;
   int            q_ch[$];
   int            q_rem[$];
   int            host_beats;
   logic          exp_m_read;
   logic [AW-1:0] exp_addr;
   logic [BW-1:0] exp_burst;
   logic [NC-1:0] exp_rdv;
   logic [DW-1:0] exp_data;
   logic          exp_err;

   task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic logic [NC*BW-1:0] bl1(input int ch, input int b);
      logic [NC*BW-1:0] r;
      r = '0;
      r[ch*BW +: BW] = BW'(b);
      return r;
   endfunction

   task automatic model_clear();
      rr = 0; outst = 0; host_beats = 0;
      q_ch.delete(); q_rem.delete();
      exp_m_read = 1'b0; exp_addr = '0; exp_burst = '0;
      exp_rdv = '0; exp_data = '0; exp_err = 1'b0;
   endtask

   task automatic do_reset();
      logic [NC-1:0] all1;
      all1 = '1;
      reset_reset = 1'b1;
      #1;
      chk("rst_m_read", m_read, 1'b0);
      chk("rst_m_address", m_address, '0);
      chk("rst_m_burstcount", m_burstcount, '0);
      chk("rst_s_readdatavalid", s_readdatavalid, '0);
      chk("rst_s_readdata", s_readdata, '0);
      chk("rst_err", err_unexpected, 1'b0);
      chk("rst_s_waitrequest", s_waitrequest, all1);
      model_clear();
      s_read = '0; m_readdatavalid = 1'b0; m_waitrequest = 1'b0;
      repeat (2) @(negedge clk_clk);
      reset_reset = 1'b0;
   endtask

   // rmode: 0 no beat, 1 forced beat, 2 random beat if host has data, 3 beat whenever host has data
   task automatic step(input logic [NC-1:0] req, input logic [NC*BW-1:0] bl,
                       input logic mw, input int rmode);
      logic          rdv, acc, found, gnt, n_mread;
      logic [NC-1:0] gvec, ewait, nrdv;
      logic [DW-1:0] d;
      logic [AW-1:0] n_addr;
      logic [BW-1:0] n_burst;
      int            g, b, raw;
      @(negedge clk_clk);
      case (rmode)
         1:       rdv = 1'b1;
         2:       rdv = (host_beats > 0) && ($urandom_range(0, 1) == 1);
         3:       rdv = (host_beats > 0);
         default: rdv = 1'b0;
      endcase
      for (int w = 0; w < DW/32; w++) d[w*32 +: 32] = $urandom;
      for (int c = 0; c < NC; c++) s_address[c*AW +: AW] = addr_in[c];
      s_read = req; s_burstcount = bl; m_waitrequest = mw;
      m_readdatavalid = rdv; m_readdata = d;
      #1;
      acc = !exp_m_read || !mw;
      found = 1'b0; g = 0;
      for (int k = 0; k < NC; k++) begin
         if (!found && req[(rr + k) % NC]) begin
            found = 1'b1;
            g = (rr + k) % NC;
         end
      end
      raw = int'(bl[g*BW +: BW]);
      b = (raw == 0) ? 1 : raw;
      gnt = acc && found && (q_ch.size() < DEPTH) && (outst + b <= MAXB);
      gvec = gnt ? NC'(1 << g) : '0;
      ewait = ~gvec;
      chk("s_waitrequest", s_waitrequest, ewait);

      if (exp_m_read && !mw) host_beats += int'(exp_burst);
      nrdv = '0;
      if (rdv) begin
         if (host_beats > 0) host_beats--;
         if (q_ch.size() > 0) begin
            nrdv = NC'(1 << q_ch[0]);
            outst--;
            q_rem[0]--;
            if (q_rem[0] == 0) begin
               void'(q_ch.pop_front());
               void'(q_rem.pop_front());
            end
         end else begin
            exp_err = 1'b1;
         end
      end
      n_mread = exp_m_read; n_addr = exp_addr; n_burst = exp_burst;
      if (gnt) begin
         q_ch.push_back(g);
         q_rem.push_back(b);
         outst += b;
         rr = (g + 1) % NC;
         n_mread = 1'b1; n_addr = addr_in[g]; n_burst = BW'(b);
      end else if (acc) begin
         n_mread = 1'b0;
      end

      @(posedge clk_clk);
      #1;
      exp_m_read = n_mread; exp_addr = n_addr; exp_burst = n_burst;
      exp_rdv = nrdv;
      if (nrdv != '0) exp_data = d;
      chk("m_read", m_read, exp_m_read);
      if (exp_m_read) begin
         chk("m_address", m_address, exp_addr);
         chk("m_burstcount", m_burstcount, exp_burst);
      end
      chk("s_readdatavalid", s_readdatavalid, exp_rdv);
      if (exp_rdv != '0) chk("s_readdata", s_readdata, exp_data);
      chk("err_unexpected", err_unexpected, exp_err);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((q_ch.size() > 0 || host_beats > 0 || exp_m_read) && n < 600) begin
         step('0, '0, 1'b0, 3);
         n++;
      end
      chk("drain_pending", q_ch.size(), 0);
      chk("drain_outstanding", outst, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int c = 0; c < NC; c++) addr_in[c] = AW'(64'h100 * (c + 1));
      model_clear();
      do_reset();

      // single channel burst of 4 at 0x1000
      addr_in[0] = 64'h1000;
      step(4'b0001, bl1(0, 4), 1'b0, 0);
      chk("single_addr", m_address, 64'h1000);
      chk("single_burst", m_burstcount, 5'd4);
      step('0, '0, 1'b0, 0);
      repeat (4) step('0, '0, 1'b0, 3);
      drain();

      // all channels burst 1, round robin
      for (int c = 0; c < NC; c++) addr_in[c] = AW'(64'hA000 + c * 64'h40);
      repeat (6) step(4'b1111, {4{5'd1}}, 1'b0, 2);
      drain();

      // master stalled 5 cycles after first request
      step(4'b1111, {4{5'd2}}, 1'b0, 0);
      repeat (5) step(4'b1111, {4{5'd2}}, 1'b1, 0);
      step('0, '0, 1'b0, 0);
      drain();

      // credit limit: four bursts of 16 fill MAX_BEATS
      repeat (6) step(4'b1111, {4{5'd16}}, 1'b0, 0);
      chk("credit_full", outst, MAXB);
      step(4'b1111, {4{5'd16}}, 1'b0, 3);
      repeat (2) step(4'b1111, {4{5'd16}}, 1'b0, 0);
      repeat (16) step(4'b1111, {4{5'd16}}, 1'b0, 3);
      drain();

      // interleaved ch2 burst 3 then ch0 burst 2
      step(4'b0100, bl1(2, 3), 1'b0, 0);
      step(4'b0001, bl1(0, 2), 1'b0, 0);
      step('0, '0, 1'b0, 0);
      repeat (5) step('0, '0, 1'b0, 3);
      drain();

      // random traffic, including burstcount 0
      for (int i = 0; i < 1500; i++) begin
         logic [NC*BW-1:0] rb;
         for (int c = 0; c < NC; c++) begin
            rb[c*BW +: BW] = BW'($urandom_range(0, 16));
            addr_in[c] = {$urandom, $urandom};
         end
         step(NC'($urandom_range(0, 15)), rb, ($urandom_range(0, 3) == 0), 2);
      end
      drain();

      // unexpected beat, sticky error
      step('0, '0, 1'b0, 1);
      repeat (3) step('0, '0, 1'b0, 0);

      // reset in the middle of a burst
      step(4'b0010, bl1(1, 8), 1'b0, 0);
      step('0, '0, 1'b0, 0);
      repeat (3) step('0, '0, 1'b0, 3);
      do_reset();

      step(4'b1000, bl1(3, 2), 1'b0, 0);
      step('0, '0, 1'b0, 0);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
